// File: rtl/rebnet_bin_pkg.sv
// Shared types and width helpers for the residual binarizer scheduler.
package rebnet_bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEVEL = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Index width for an n-entry table; never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter
    import rebnet_bin_pkg::*;
#(
    parameter int N = 4,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % N;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[wrap_idx(int'(ptr), k)]) begin
                any = 1'b1;
                grant[wrap_idx(int'(ptr), k)] = 1'b1;
                idx = W'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/binarize_scheduler.sv
// Shares one multi-level residual binarizer among N_LANES popcount lanes,
// arbitrated round-robin, with a per-level gamma register file.
module binarize_scheduler
    import rebnet_bin_pkg::*;
#(
    parameter int N_LANES              = 4,
    parameter int Twidth               = 24,
    parameter int binary_output_levels = 2,
    localparam int LANE_W = idx_width(N_LANES),
    localparam int LVL_W  = idx_width(binary_output_levels)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_LANES-1:0]                in_valid,
    output logic [N_LANES-1:0]                in_ready,
    input  logic [N_LANES*Twidth-1:0]         in_pixel,
    input  logic                              gamma_we,
    input  logic [LVL_W-1:0]                  gamma_addr,
    input  logic [Twidth-1:0]                 gamma_data,
    output logic                              cfg_busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [binary_output_levels-1:0]   out_bits,
    output logic [LANE_W-1:0]                 out_lane,
    output logic [Twidth-1:0]                 out_residual
);

    localparam int M = binary_output_levels;

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is only offered to a lane already raising
    // in_valid, and out_* hold steady from out_valid until out_ready.

    state_t              state, state_nx;
    logic [LANE_W-1:0]   rr_ptr, lane_q, grant_idx;
    logic [N_LANES-1:0]  grant;
    logic                grant_any;
    logic [LVL_W-1:0]    lvl_q;
    logic [Twidth-1:0]   r_q;
    logic [M-1:0]        bits_q;
    logic [Twidth-1:0]   gamma_q [M];

    logic                accept, level_last, sign_bit, gamma_wr;
    logic [Twidth-1:0]   gamma_sel, r_sub, r_add, pixel_sel;

    rr_arbiter #(.N(N_LANES)) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign in_ready     = (state == IDLE) ? grant : '0;
    assign accept       = (state == IDLE) && grant_any;
    assign cfg_busy     = (state != IDLE);
    assign out_valid    = (state == OUT);
    assign out_bits     = bits_q;
    assign out_lane     = lane_q;
    assign out_residual = r_q;

    assign pixel_sel  = in_pixel[grant_idx*Twidth +: Twidth];
    assign level_last = (lvl_q == LVL_W'(M - 1));
    assign gamma_sel  = gamma_q[lvl_q];
    // Zero counts as non-negative, so the emitted bit is the inverted MSB.
    assign sign_bit   = ~r_q[Twidth-1];
    assign r_sub      = r_q - gamma_sel;
    assign r_add      = r_q + gamma_sel;
    assign gamma_wr   = gamma_we && (state == IDLE) && (int'(gamma_addr) < M);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = LEVEL;
            LEVEL:   if (level_last) state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < M; i++) gamma_q[i] <= '0;
        end else if (gamma_wr) begin
            gamma_q[gamma_addr] <= gamma_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            lane_q <= '0;
            lvl_q  <= '0;
            r_q    <= '0;
            bits_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                r_q    <= pixel_sel;
                lane_q <= grant_idx;
                lvl_q  <= '0;
                rr_ptr <= (int'(grant_idx) == N_LANES - 1) ? '0
                                                           : grant_idx + LANE_W'(1);
            end else if (state == LEVEL) begin
                bits_q[lvl_q] <= sign_bit;
                r_q           <= sign_bit ? r_sub : r_add;
                lvl_q         <= level_last ? '0 : lvl_q + LVL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_binarize_scheduler.sv
// Bench for binarize_scheduler: vector table, corner sequences and
// randomized traffic against a behavioural model with a result queue.
module tb_binarize_scheduler;
    import rebnet_bin_pkg::*;

    localparam int N  = 4;
    localparam int TW = 24;
    localparam int M  = 2;
    localparam int LW = 2;
    localparam int GW = 1;
    localparam int W  = LW + M + TW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*TW-1:0] in_pixel = '0;
    logic            gamma_we = 1'b0;
    logic [GW-1:0]   gamma_addr = '0;
    logic [TW-1:0]   gamma_data = '0;
    logic            cfg_busy;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [M-1:0]    out_bits;
    logic [LW-1:0]   out_lane;
    logic [TW-1:0]   out_residual;

    binarize_scheduler #(
        .N_LANES(N), .Twidth(TW), .binary_output_levels(M)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .gamma_we(gamma_we), .gamma_addr(gamma_addr), .gamma_data(gamma_data),
        .cfg_busy(cfg_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_lane(out_lane), .out_residual(out_residual)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TW-1:0] m_gamma [M];
    logic [W-1:0]  exp_q [$];
    int            grant_log [$];
    int            hs_cyc [$];
    int            m_ptr = 0;
    bit            m_busy = 0;
    int            m_cnt = 0;
    bit            prev_stall = 0;
    logic [W-1:0]  prev_out;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Residual binarization in plain integer arithmetic, wrapped to TW bits.
    function automatic logic [M+TW-1:0] binarize(input logic [TW-1:0] pix);
        longint        r;
        logic [TW-1:0] t;
        logic [M-1:0]  b;
        t = pix;
        r = longint'($signed(pix));
        for (int i = 0; i < M; i++) begin
            b[i] = (r >= 0);
            if (b[i]) r = r - longint'($signed(m_gamma[i]));
            else      r = r + longint'($signed(m_gamma[i]));
            t = r[TW-1:0];
            r = longint'($signed(t));
        end
        return {b, t};
    endfunction

    always @(negedge clk) begin : monitor
        int g;
        if (!rst) begin
            m_busy = 0;
            m_ptr = 0;
            m_cnt = 0;
            prev_stall = 0;
            exp_q.delete();
            for (int i = 0; i < M; i++) m_gamma[i] = '0;
        end else if (!m_busy) begin
            if (gamma_we && int'(gamma_addr) < M) m_gamma[gamma_addr] = gamma_data;
            g = pick(in_valid, m_ptr);
            check("idle_cfg_busy", cfg_busy, 0);
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, (g < 0) ? 0 : (1 << g));
            if (g >= 0) begin
                exp_q.push_back({LW'(g), binarize(in_pixel[g*TW +: TW])});
                grant_log.push_back(g);
                m_ptr = (g + 1) % N;
                m_busy = 1;
                m_cnt = 0;
            end
        end else begin
            m_cnt++;
            check("busy_in_ready", in_ready, 0);
            check("busy_cfg_busy", cfg_busy, 1);
            check("busy_out_valid", out_valid, (m_cnt >= M + 1) ? 1 : 0);
            if (out_valid) begin
                if (prev_stall)
                    check("out_stable", {out_lane, out_bits, out_residual}, prev_out);
                prev_stall = !out_ready;
                prev_out = {out_lane, out_bits, out_residual};
                if (out_ready) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0)
                        check("out_unexpected", {out_lane, out_bits, out_residual}, 'x);
                    else
                        check("out_result", {out_lane, out_bits, out_residual}, exp_q.pop_front());
                    m_busy = 0;
                    prev_stall = 0;
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_gamma(input int a, input logic [TW-1:0] d);
        gamma_we = 1'b1;
        gamma_addr = GW'(a);
        gamma_data = d;
        @(posedge clk); #1;
        gamma_we = 1'b0;
    endtask

    task automatic run_txn(input int lane, input logic [TW-1:0] pix, input logic [M-1:0] eb,
                           input logic [TW-1:0] er, input int stall, input string nm);
        int n;
        int lat;
        out_ready = (stall == 0);
        in_pixel[lane*TW +: TW] = pix;
        in_valid[lane] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[lane] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[lane]) begin
            check({nm, "_grant"}, in_ready[lane], 1);
            in_valid[lane] = 1'b0;
            gamma_we = 1'b0;
            out_ready = 1'b1;
            return;
        end
        @(posedge clk); #1;
        in_valid[lane] = 1'b0;
        gamma_we = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({nm, "_latency"}, lat, M + 1);
        check({nm, "_bits"}, out_bits, eb);
        check({nm, "_residual"}, out_residual, er);
        check({nm, "_lane"}, out_lane, lane);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            gamma_we = 1'b1;
            gamma_addr = 1;
            gamma_data = 24'd100;
            @(negedge clk);
            check({nm, "_hold_valid"}, out_valid, 1);
            check({nm, "_hold_bits"}, out_bits, eb);
            check({nm, "_hold_residual"}, out_residual, er);
            check({nm, "_hold_in_ready"}, in_ready, 0);
            check({nm, "_hold_cfg_busy"}, cfg_busy, 1);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            gamma_we = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((m_busy || exp_q.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            lane;
        logic [TW-1:0] pix;
        logic [TW-1:0] g0;
        logic [TW-1:0] g1;
        logic [M-1:0]  bits;
        logic [TW-1:0] res;
    } vec_t;

    vec_t tbl [9];
    int   exp_order [5];
    logic [N-1:0] hs;

    initial begin
        tbl[0] = '{0, TW'(7),        TW'(10), TW'(4), 2'b01, TW'(1)};
        tbl[1] = '{2, TW'(-5),       TW'(10), TW'(4), 2'b10, TW'(1)};
        tbl[2] = '{1, TW'(0),        TW'(10), TW'(4), 2'b01, TW'(-6)};
        tbl[3] = '{3, TW'(-1),       TW'(10), TW'(4), 2'b10, TW'(5)};
        tbl[4] = '{0, TW'(8388607),  TW'(10), TW'(4), 2'b11, TW'(8388593)};
        tbl[5] = '{1, TW'(-8388608), TW'(10), TW'(4), 2'b00, TW'(-8388594)};
        tbl[6] = '{2, TW'(10),       TW'(10), TW'(4), 2'b11, TW'(-4)};
        tbl[7] = '{3, TW'(100),      TW'(0),  TW'(0), 2'b11, TW'(100)};
        tbl[8] = '{0, TW'(5),        TW'(3),  TW'(7), 2'b11, TW'(-5)};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset: arbiter is combinational in IDLE, registered outputs cleared.
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 4'b0100;
        @(negedge clk);
        check("reset_in_ready", in_ready, 4'b0100);
        @(posedge clk); #1;
        in_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("reset_cfg_busy", cfg_busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_bits", out_bits, 0);
        check("reset_out_lane", out_lane, 0);
        check("reset_out_residual", out_residual, 0);
        check("reset_in_ready_idle", in_ready, 0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            write_gamma(0, tbl[i].g0);
            write_gamma(1, tbl[i].g1);
            run_txn(tbl[i].lane, tbl[i].pix, tbl[i].bits, tbl[i].res, 0, $sformatf("vec%0d", i));
        end

        // Output stall with a gamma write that must be dropped.
        write_gamma(0, TW'(10));
        write_gamma(1, TW'(4));
        run_txn(1, TW'(7), 2'b01, TW'(1), 5, "stall");
        run_txn(2, TW'(7), 2'b01, TW'(1), 0, "after_drop");

        // Gamma write in the same cycle as the grant: new gamma1 = 6.
        gamma_we = 1'b1;
        gamma_addr = 1;
        gamma_data = TW'(6);
        run_txn(0, TW'(7), 2'b01, TW'(3), 0, "wr_grant");

        // Reset in LEVEL aborts; pointer and gammas come back cleared.
        in_pixel[2*TW +: TW] = TW'(50);
        in_valid[2] = 1'b1;
        @(negedge clk);
        check("abort_grant", in_ready, 4'b0100);
        @(posedge clk); #1;
        in_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_cfg_busy", cfg_busy, 0);
        check("abort_out_bits", out_bits, 0);
        check("abort_out_residual", out_residual, 0);
        @(posedge clk); #1;
        in_pixel[3*TW +: TW] = TW'(3);
        in_valid[3] = 1'b1;
        run_txn(1, TW'(3), 2'b11, TW'(3), 0, "after_abort");
        @(negedge clk);
        @(posedge clk); #1;
        in_valid[3] = 1'b0;
        drain("abort");

        // All lanes requesting: grant order and back-to-back throughput.
        write_gamma(0, TW'(10));
        write_gamma(1, TW'(4));
        grant_log.delete();
        hs_cyc.delete();
        for (int l = 0; l < N; l++) in_pixel[l*TW +: TW] = TW'($urandom);
        in_valid = '1;
        for (int n = 0; n < 100 && grant_log.size() < 5; n++) begin
            @(posedge clk); #1;
            for (int l = 0; l < N; l++) in_pixel[l*TW +: TW] = TW'($urandom);
        end
        in_valid = '0;
        drain("rr");
        check("rr_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check($sformatf("rr_order%0d", i), grant_log[i], exp_order[i]);
        check("rr_result_count", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++)
            check($sformatf("rr_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], M + 2);

        // Randomized traffic: requests held until granted, random backpressure.
        for (int t = 0; t < 800; t++) begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk); #1;
            for (int l = 0; l < N; l++) begin
                if (hs[l]) in_valid[l] = ($urandom_range(0, 3) == 0);
                else if (!in_valid[l]) in_valid[l] = ($urandom_range(0, 2) == 0);
                if (hs[l] || !in_valid[l]) in_pixel[l*TW +: TW] = TW'($urandom);
            end
            out_ready = ($urandom_range(0, 1) == 1);
            gamma_we = ($urandom_range(0, 7) == 0);
            gamma_addr = GW'($urandom_range(0, M - 1));
            gamma_data = TW'($urandom_range(0, 5000));
        end
        in_valid = '0;
        gamma_we = 1'b0;
        out_ready = 1'b1;
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
